ring_counter_param: RTL and testbench

//   Parametrised synchronous ring / Johnson (twisted-ring) counter with enable, direction, parallel load,

---
 rtl/ring_counter_pkg.sv | 49 ++++
 rtl/ring_counter_param_stage.sv | 28 ++
 rtl/ring_counter_param.sv | 110 +++++++++++
 tb/tb_ring_counter_param.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// ring_counter_pkg
//   Shared constants and helpers for the parametrised ring / Johnson counter.
//   MODE_* selects the ring flavour; DIR_* selects the shift direction.
//   seed()     : reset/restart pattern for a mode at a given width.
//   is_legal() : true when a state belongs to the mode's normal cycle.
//   Helpers operate on MAX_W-bit vectors; callers cast their WIDTH-bit
//   values in and out, so WIDTH must not exceed MAX_W.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b0;  // toward MSB
  localparam logic DIR_DN       = 1'b1;  // toward LSB
  localparam int   MAX_W        = 64;

  function automatic logic [MAX_W-1:0] seed(input logic mode, input int width);
    seed = '0;
    if (mode == MODE_RING && width > 0) seed[0] = 1'b1;
  endfunction

  // Ones-mask of the low k bits, saturating at MAX_W.
  function automatic logic [MAX_W-1:0] low_mask(input int k);
    if (k >= MAX_W) low_mask = '1;
    else            low_mask = (64'd1 << k) - 64'd1;
  endfunction

  // Ring: exactly one bit set.  Johnson: a run of ones anchored at the LSB
  // or at the MSB (the run anchored at the MSB is the complement of an
  // LSB-anchored run within the width).
  function automatic logic is_legal(input logic mode, input int width,
                                    input logic [MAX_W-1:0] v);
    logic [MAX_W-1:0] wmask;
    logic [MAX_W-1:0] inv;
    int               cnt;
    is_legal = 1'b0;
    wmask    = low_mask(width);
    inv      = ~v & wmask;
    cnt      = 0;
    if (mode == MODE_RING) begin
      for (int i = 0; i < width; i++)
        if (v[i]) cnt++;
      is_legal = (cnt == 1);
    end else begin
      for (int k = 0; k <= width; k++)
        if (v == low_mask(k) || inv == low_mask(k)) is_legal = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ring_counter_param_stage.sv
// ring_stage
//   One flop of the ring. Priority: rst > ld > en > hold.
//   clk     : rising-edge clock
//   rst     : synchronous reset, active-high; loads rst_val
//   rst_val : this bit of the seed pattern
//   ld      : force load of ld_val (parallel load, mode restart, correction)
//   ld_val  : value for ld
//   en      : take d (shifted neighbour) this cycle
//   d       : next value from the shift network
//   q       : stage output
module ring_stage (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ld,
  input  logic ld_val,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= rst_val;
    else if (ld) q <= ld_val;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ring_counter_param.sv
// ring_counter_param
//   Parametrised synchronous ring / Johnson counter with enable, direction,
//   parallel load, registered step index (pos), wrap strobe and optional
//   illegal-state self-correction.
//   Macro RING_SELF_CORRECT_EN: when defined, an enabled step from an
//   illegal state restarts at the seed and pulses err; when undefined,
//   err is tied low and no detector is built.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     en, dir, mode   : step enable, 0=toward MSB / 1=toward LSB, 0=ring / 1=Johnson
//     load, load_val  : parallel load strobe and value
//     q               : counter state
//     pos             : step index since seed, modulo period (W or 2W)
//     wrap            : pulse after a step that returned q to seed
//     err             : pulse after an illegal state was corrected
module ring_counter_param
  import ring_counter_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int POS_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             err
);

  logic             mode_q;
  logic             mode_chg;
  logic             step;
  logic             corr;
  logic             ld;
  logic [WIDTH-1:0] seed_v;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ld_v;
  logic [POS_W-1:0] last;
  logic [POS_W-1:0] pos_nxt;

  // Seed follows the mode input so reset and mode restarts land on the
  // pattern of the mode being entered.
  assign seed_v   = WIDTH'(seed(mode, WIDTH));
  assign mode_chg = (mode != mode_q);
  assign step     = en & ~load & ~mode_chg;
  assign ld       = load | mode_chg | corr;
  assign ld_v     = load ? load_val : seed_v;
  assign last     = (mode_q == MODE_JOHNSON) ? POS_W'(2*WIDTH-1) : POS_W'(WIDTH-1);

  // Johnson feedback is the ring feedback inverted; mode_q is 1 for Johnson.
  always_comb begin
    if (dir == DIR_UP) nxt = {q[WIDTH-2:0], q[WIDTH-1] ^ mode_q};
    else               nxt = {q[0] ^ mode_q, q[WIDTH-1:1]};
  end

  always_comb begin
    pos_nxt = pos;
    if (dir == DIR_UP) pos_nxt = (pos == last)     ? '0   : pos + POS_W'(1);
    else               pos_nxt = (pos == '0)       ? last : pos - POS_W'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    ring_stage u_stage (
      .clk     (clk),
      .rst     (rst),
      .rst_val (seed_v[i]),
      .ld      (ld),
      .ld_val  (ld_v[i]),
      .en      (en),
      .d       (nxt[i]),
      .q       (q[i])
    );
  end

  // mode_q tracks mode every cycle; a mode change coinciding with a load is
  // absorbed by the load (load has priority and defines the new state).
  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (rst) begin
      pos  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (ld)
        pos <= '0;
      else if (step) begin
        pos  <= pos_nxt;
        wrap <= (nxt == seed_v);
      end
    end
  end

`ifdef RING_SELF_CORRECT_EN
  assign corr = step & ~is_legal(mode_q, WIDTH, MAX_W'(q));

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= corr;
  end
`else
  assign corr = 1'b0;
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_ring_counter_param.sv
// tb_ring_counter_param
//   Directed vectors with hand-computed expectations for WIDTH=4 and a
//   WIDTH=8 Johnson run. Inputs change 1 time unit after the rising edge;
//   outputs are sampled at the same point, after the edge has settled.
module tb_ring_counter_param;

  logic       clk = 1'b0;
  logic       rst, en, dir, mode, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] pos;
  logic       wrap, err;

  logic       rst8, en8, dir8, mode8, load8;
  logic [7:0] load_val8;
  logic [7:0] q8;
  logic [3:0] pos8;
  logic       wrap8, err8;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  ring_counter_param #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .q(q), .pos(pos), .wrap(wrap), .err(err)
  );

  ring_counter_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .dir(dir8), .mode(mode8), .load(load8),
    .load_val(load_val8), .q(q8), .pos(pos8), .wrap(wrap8), .err(err8)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // q, pos, wrap of the WIDTH=4 instance
  task automatic chk4(input string tag, input int eq, input int ep, input int ew);
    chk({tag, ".q"},    32'(q),    eq);
    chk({tag, ".pos"},  32'(pos),  ep);
    chk({tag, ".wrap"}, 32'(wrap), ew);
  endtask

  logic [3:0] ring_up [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] john_up [8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000, 4'b0000};
  int wraps;

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;
    rst8 = 1'b1; en8 = 1'b0; dir8 = 1'b0; mode8 = 1'b1; load8 = 1'b0; load_val8 = '0;

    // 1: ring reset and four steps up
    tick();
    chk4("t1.rst", 4'b0001, 0, 0);
    chk("t1.rst.err", 32'(err), 0);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk4($sformatf("t1.s%0d", i), ring_up[i], (i + 1) % 4, (i == 3) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    chk4("t1.hold", 4'b0001, 0, 0);

    // 2: Johnson reset and eight steps up
    rst = 1'b1; mode = 1'b1;
    tick();
    chk4("t2.rst", 4'b0000, 0, 0);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk4($sformatf("t2.s%0d", i), john_up[i], (i + 1) % 8, (i == 7) ? 1 : 0);
    end

    // 3: ring, down from seed then back up
    rst = 1'b1; mode = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    chk4("t3.dn", 4'b1000, 3, 0);
    dir = 1'b0;
    tick();
    chk4("t3.up", 4'b0001, 0, 1);

    // 4: load beats en; mode change restarts without stepping
    load = 1'b1; load_val = 4'b0100;
    tick();
    chk4("t4.load", 4'b0100, 0, 0);
    load = 1'b0; mode = 1'b1;
    tick();
    chk4("t4.mode", 4'b0000, 0, 0);
    tick();
    chk4("t4.step", 4'b0001, 1, 0);

    // 5: illegal ring state
    mode = 1'b0; en = 1'b0;
    tick();
    chk4("t5.restart", 4'b0001, 0, 0);
    load = 1'b1; load_val = 4'b0110;
    tick();
    chk4("t5.load", 4'b0110, 0, 0);
    chk("t5.load.err", 32'(err), 0);
    load = 1'b0; en = 1'b1;
    tick();
`ifdef RING_SELF_CORRECT_EN
    chk4("t5.fix", 4'b0001, 0, 0);
    chk("t5.fix.err", 32'(err), 1);
    tick();
    chk4("t5.next", 4'b0010, 1, 0);
    chk("t5.next.err", 32'(err), 0);
`else
    chk4("t5.rot", 4'b1100, 1, 0);
    chk("t5.rot.err", 32'(err), 0);
    tick();
    chk4("t5.next", 4'b1001, 2, 0);
    chk("t5.next.err", 32'(err), 0);
`endif

    // 6: reset mid-count overrides en
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk4("t6.mid", 4'b0100, 2, 0);
    rst = 1'b1;
    tick();
    chk4("t6.rst", 4'b0001, 0, 0);
    rst = 1'b0; en = 1'b0;

    // 6b: WIDTH=8 Johnson full period
    rst8 = 1'b0;
    chk("t6b.rst.q", 32'(q8), 0);
    chk("t6b.rst.pos", 32'(pos8), 0);
    en8 = 1'b1;
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (wrap8) wraps++;
      chk($sformatf("t6b.s%0d.pos", i), 32'(pos8), (i + 1) % 16);
      chk($sformatf("t6b.s%0d.wrap", i), 32'(wrap8), (i == 15) ? 1 : 0);
      if (i == 7) chk("t6b.full", 32'(q8), 32'hFF);
    end
    chk("t6b.q", 32'(q8), 0);
    chk("t6b.wraps", wraps, 1);
    chk("t6b.err", 32'(err8), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
